// File: rtl/display_pkg.sv
// Shared constants and anode helper for the four-digit multiplexed display.
package display_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int IDX_W      = 2;

  localparam logic [NUM_DIGITS-1:0] AN_OFF   = 4'b1111;
  localparam logic [IDX_W-1:0]      LAST_IDX = 2'd3;

  // One-hot-low enable: only the anode of the selected digit is pulled low.
  function automatic logic [NUM_DIGITS-1:0] anode_pattern(input logic [IDX_W-1:0] idx);
    anode_pattern = AN_OFF & ~(NUM_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Prescaler for the digit scan: counts 0..CLK_DIV-1 and flags the last count.
module scan_tick_gen #(
  parameter int CLK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int                CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    tick  = (cnt_q == CNT_MAX);
    cnt_d = cnt_q + CNT_W'(1);
    if (tick) begin
      cnt_d = '0;
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/display_scan_mux.sv
// Four-digit BCD scan multiplexer with tear-free frame-boundary updates.
// Optional leading-zero blanking is enabled by defining DISPLAY_SCAN_LZB_EN.
module display_scan_mux
  import display_pkg::*;
#(
  parameter int CLK_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic        load,
  output logic [3:0]  bcd,
  output logic [3:0]  an,
  output logic [1:0]  digit_idx,
  output logic        pending
);

  localparam int VAL_W = NUM_DIGITS * DIGIT_W;

  logic             tick;
  logic             frame_end;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [VAL_W-1:0] disp_q, disp_d;
  logic [VAL_W-1:0] pend_val_q, pend_val_d;
  logic             pend_q, pend_d;

  scan_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign frame_end = tick && (idx_q == LAST_IDX);

  // The display register only moves on the frame boundary, so a frame never mixes two values.
  always_comb begin
    idx_d      = idx_q;
    disp_d     = disp_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    if (tick) begin
      idx_d = idx_q + IDX_W'(1);
    end
    if (frame_end) begin
      if (load) begin
        disp_d = value;
      end else if (pend_q) begin
        disp_d = pend_val_q;
      end
      pend_d = 1'b0;
    end else if (load) begin
      pend_val_d = value;
      pend_d     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q      <= '0;
      disp_q     <= '0;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      disp_q     <= disp_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
    end
  end

  // All three scan outputs decode from the same registers, giving zero skew between them.
  always_comb begin
    bcd = disp_q[idx_q*DIGIT_W +: DIGIT_W];
    an  = anode_pattern(idx_q);
`ifdef DISPLAY_SCAN_LZB_EN
    if ((idx_q != '0) && ((disp_q >> (idx_q * DIGIT_W)) == '0)) begin
      an = AN_OFF;
    end
`endif
  end

  assign digit_idx = idx_q;
  assign pending   = pend_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed self-checking bench for display_scan_mux with CLK_DIV=4.
// Expected anodes follow DISPLAY_SCAN_LZB_EN when the bench is built with it.
module tb_display_scan_mux;

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic        load;
  logic [3:0]  bcd;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        pending;

  int checks = 0;
  int errors = 0;

  display_scan_mux #(
    .CLK_DIV (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .value     (value),
    .load      (load),
    .bcd       (bcd),
    .an        (an),
    .digit_idx (digit_idx),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_an(input int d, input logic [15:0] v);
    logic [3:0] p;
    p    = 4'b1111;
    p[d] = 1'b0;
`ifdef DISPLAY_SCAN_LZB_EN
    if (d > 0 && (v >> (4 * d)) == 16'h0) p = 4'b1111;
`endif
    return p;
  endfunction

  function automatic logic [3:0] nib(input logic [15:0] v, input int d);
    logic [15:0] s;
    s = v >> (4 * d);
    return s[3:0];
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic advance(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Called at slot idx0/count0; loads on the frame-boundary tick.
  task automatic load_at_boundary(input logic [15:0] v);
    advance(15);
    value = v;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  task automatic check_frame(input logic [15:0] v);
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        check("frame_bcd", {12'h0, bcd}, {12'h0, nib(v, d)});
        check("frame_an", {12'h0, an}, {12'h0, exp_an(d, v)});
        check("frame_idx", {14'h0, digit_idx}, 16'(d));
        check("frame_pending", {15'h0, pending}, 16'h0);
        step();
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    load  = 1'b0;
    value = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_an", {12'h0, an}, 16'h000E);
    check("rst_bcd", {12'h0, bcd}, 16'h0);
    check("rst_idx", {14'h0, digit_idx}, 16'h0);
    check("rst_pending", {15'h0, pending}, 16'h0);

    // First anode change lands on the 4th edge after release.
    for (int k = 1; k <= 4; k++) begin
      step();
      check("first_tick_an", {12'h0, an}, {12'h0, (k < 4) ? exp_an(0, 16'h0) : exp_an(1, 16'h0)});
      check("first_tick_idx", {14'h0, digit_idx}, (k < 4) ? 16'h0 : 16'h1);
    end

    // Load coincident with the idx3 tick goes straight to the display.
    advance(11);
    value = 16'h1234;
    load  = 1'b1;
    step();
    load  = 1'b0;
    check_frame(16'h1234);

    // Mid-frame load waits for the boundary.
    advance(4);
    value = 16'h5678;
    load  = 1'b1;
    step();
    load  = 1'b0;
    check("tear_pend1", {15'h0, pending}, 16'h1);
    check("tear_bcd1", {12'h0, bcd}, 16'h3);
    advance(3);
    check("tear_bcd2", {12'h0, bcd}, 16'h2);
    check("tear_pend2", {15'h0, pending}, 16'h1);
    advance(4);
    check("tear_bcd3", {12'h0, bcd}, 16'h1);
    check("tear_pend3", {15'h0, pending}, 16'h1);
    advance(4);
    check("tear_wrap_bcd", {12'h0, bcd}, 16'h8);
    check("tear_wrap_pend", {15'h0, pending}, 16'h0);
    check("tear_wrap_an", {12'h0, an}, 16'h000E);
    advance(4);
    check("tear_next_bcd", {12'h0, bcd}, 16'h7);

    // Two loads in one frame: the later one wins.
    value = 16'h1111;
    load  = 1'b1;
    step();
    load  = 1'b0;
    check("ovw_pend1", {15'h0, pending}, 16'h1);
    check("ovw_bcd1", {12'h0, bcd}, 16'h7);
    advance(3);
    value = 16'h2222;
    load  = 1'b1;
    step();
    load  = 1'b0;
    check("ovw_pend2", {15'h0, pending}, 16'h1);
    check("ovw_bcd2", {12'h0, bcd}, 16'h6);
    advance(3);
    check("ovw_bcd3", {12'h0, bcd}, 16'h5);
    advance(4);
    check_frame(16'h2222);

    // Non-decimal nibbles pass through; zero patterns exercise blanking.
    load_at_boundary(16'h0FA0);
    check_frame(16'h0FA0);
    load_at_boundary(16'h0050);
    check_frame(16'h0050);
    load_at_boundary(16'h0000);
    check_frame(16'h0000);
    load_at_boundary(16'h1234);
    check_frame(16'h1234);

    // Reset at idx2 with a value pending, alongside a load.
    advance(4);
    value = 16'h4321;
    load  = 1'b1;
    step();
    load  = 1'b0;
    check("mrst_pend_before", {15'h0, pending}, 16'h1);
    advance(3);
    check("mrst_idx_before", {14'h0, digit_idx}, 16'h2);
    rst_n = 1'b0;
    value = 16'hFFFF;
    load  = 1'b1;
    step();
    check("mrst_pending", {15'h0, pending}, 16'h0);
    check("mrst_idx", {14'h0, digit_idx}, 16'h0);
    check("mrst_bcd", {12'h0, bcd}, 16'h0);
    check("mrst_an", {12'h0, an}, 16'h000E);
    rst_n = 1'b1;
    load  = 1'b0;
    advance(4);
    check("mrst_idx1", {14'h0, digit_idx}, 16'h1);
    check("mrst_bcd1", {12'h0, bcd}, 16'h0);
    advance(12);
    check("mrst_wrap_idx", {14'h0, digit_idx}, 16'h0);
    check("mrst_wrap_bcd", {12'h0, bcd}, 16'h0);
    check("mrst_wrap_pend", {15'h0, pending}, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
